ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver for the keyboard path. It deframes 11-bit PS/2 frames and checks parity, stop bit and inter-bit timeout. It can optionally translate scan-code set 2 to XT set 1, folding the F0 break prefix into bit 7. Accepted codes go into a first-word-fall-through FIFO that the CPU-side port logic drains. It sits between the PS/2 clock edge detector and the keyboard I/O port.

---
 rtl/ps2_rx_fifo.sv | 163 ++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard frame receiver with optional set-2 to set-1 translation
// feeding a first-word-fall-through FIFO.
module ps2_rx_fifo #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int XLATE          = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       ps2_clk_posedge,
    input  logic                       ps2_data,
    input  logic                       rd_en,
    input  logic                       err_clr,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       frame_err,
    output logic                       overflow,
    output logic                       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            par_q, par_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            brk_q, brk_d;
    logic            ferr_d, timeout, push, pop, full, wr, ovf_set;
    logic [7:0]      push_data;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;
    logic            ovf_q;

    function automatic logic [7:0] xlate(input logic [7:0] b);
        case (b)
            8'h01: return 8'h43; 8'h03: return 8'h3F; 8'h04: return 8'h3D; 8'h05: return 8'h3B;
            8'h06: return 8'h3C; 8'h07: return 8'h58; 8'h09: return 8'h44; 8'h0A: return 8'h42;
            8'h0B: return 8'h40; 8'h0C: return 8'h3E; 8'h0D: return 8'h0F; 8'h0E: return 8'h29;
            8'h11: return 8'h38; 8'h12: return 8'h2A; 8'h14: return 8'h1D; 8'h15: return 8'h10;
            8'h16: return 8'h02; 8'h1A: return 8'h2C; 8'h1B: return 8'h1F; 8'h1C: return 8'h1E;
            8'h1D: return 8'h11; 8'h1E: return 8'h03; 8'h21: return 8'h2E; 8'h22: return 8'h2D;
            8'h23: return 8'h20; 8'h24: return 8'h12; 8'h25: return 8'h05; 8'h26: return 8'h04;
            8'h29: return 8'h39; 8'h2A: return 8'h2F; 8'h2B: return 8'h21; 8'h2C: return 8'h14;
            8'h2D: return 8'h13; 8'h2E: return 8'h06; 8'h31: return 8'h31; 8'h32: return 8'h30;
            8'h33: return 8'h23; 8'h34: return 8'h22; 8'h35: return 8'h15; 8'h36: return 8'h07;
            8'h3A: return 8'h32; 8'h3B: return 8'h24; 8'h3C: return 8'h16; 8'h3D: return 8'h08;
            8'h3E: return 8'h09; 8'h41: return 8'h33; 8'h42: return 8'h25; 8'h43: return 8'h17;
            8'h44: return 8'h18; 8'h45: return 8'h0B; 8'h46: return 8'h0A; 8'h49: return 8'h34;
            8'h4A: return 8'h35; 8'h4B: return 8'h26; 8'h4C: return 8'h27; 8'h4D: return 8'h19;
            8'h4E: return 8'h0C; 8'h52: return 8'h28; 8'h54: return 8'h1A; 8'h55: return 8'h0D;
            8'h58: return 8'h3A; 8'h59: return 8'h36; 8'h5A: return 8'h1C; 8'h5B: return 8'h1B;
            8'h5D: return 8'h2B; 8'h61: return 8'h56; 8'h66: return 8'h0E; 8'h69: return 8'h4F;
            8'h6B: return 8'h4B; 8'h6C: return 8'h47; 8'h70: return 8'h52; 8'h71: return 8'h53;
            8'h72: return 8'h50; 8'h73: return 8'h4C; 8'h74: return 8'h4D; 8'h75: return 8'h48;
            8'h76: return 8'h01; 8'h77: return 8'h45; 8'h78: return 8'h57; 8'h79: return 8'h4E;
            8'h7A: return 8'h51; 8'h7B: return 8'h4A; 8'h7C: return 8'h37; 8'h7D: return 8'h49;
            8'h7E: return 8'h46; 8'h83: return 8'h41;
            default: return b;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        brk_d     = brk_q;
        ferr_d    = 1'b0;
        push      = 1'b0;
        push_data = shift_q;
        tmo_d     = (state_q == IDLE || ps2_clk_posedge) ? '0 : tmo_q + 1'b1;
        // A strobe landing on the last allowed cycle still counts as in time
        timeout   = state_q != IDLE && !ps2_clk_posedge && tmo_q == TW'(TIMEOUT_CYCLES - 1);
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (timeout) begin
            state_d = IDLE;
            cnt_d   = '0;
            ferr_d  = 1'b1;
            brk_d   = 1'b0;
        end else if (ps2_clk_posedge) begin
            case (state_q)
                IDLE: if (!ps2_data) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
                DATA: begin
                    shift_d = {ps2_data, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    state_d = cnt_q == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = ps2_data;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (!ps2_data || !(^shift_q ^ par_q)) begin
                        ferr_d = 1'b1;
                        brk_d  = 1'b0;
                    end else if (XLATE == 0 || shift_q == 8'hE0 || shift_q == 8'hE1) begin
                        push = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_data = xlate(shift_q) | {brk_q, 7'b0};
                        brk_d     = 1'b0;
                    end
                end
            endcase
        end
    end

    assign pop     = rd_en && count_q != '0;
    assign full    = count_q == CW'(DEPTH);
    assign wr      = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            brk_q     <= 1'b0;
            frame_err <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            brk_q     <= brk_d;
            frame_err <= ferr_d;
            if (wr) mem_q[wptr_q] <= push_data;
            wptr_q    <= wptr_q + AW'(wr);
            rptr_q    <= rptr_q + AW'(pop);
            count_q   <= count_q + CW'(wr) - CW'(pop);
            ovf_q     <= ovf_set ? 1'b1 : err_clr ? 1'b0 : ovf_q;
        end
    end

    assign rd_data    = mem_q[rptr_q];
    assign rd_valid   = count_q != '0;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed frames with a scoreboard queue drained by a monitor
// that pops and compares the FIFO head whenever it is allowed to read.
module tb_ps2_rx_fifo;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic       clk = 1'b0, reset = 1'b0, enable = 1'b1, strobe = 1'b0, ps2_data = 1'b1;
    logic       rd_en = 1'b0, err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, frame_err, overflow, busy;
    logic [2:0] fifo_count;

    int         checks = 0, errors = 0, pops_left = 0;
    bit         drain = 1'b1;
    logic [7:0] exp_q[$];

    ps2_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .XLATE(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ps2_clk_posedge(strobe),
        .ps2_data(ps2_data), .rd_en(rd_en), .err_clr(err_clr), .rd_data(rd_data),
        .rd_valid(rd_valid), .fifo_count(fifo_count), .frame_err(frame_err),
        .overflow(overflow), .busy(busy));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare and pop the head on the falling edge so the pop lands on the next rising edge
    always @(negedge clk) begin
        if (rd_valid && (drain || pops_left > 0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h with no entry expected", rd_data);
            end else chk("sb_data", rd_data, exp_q.pop_front());
            if (pops_left > 0) pops_left--;
            rd_en = 1'b1;
        end else rd_en = 1'b0;
    end

    task automatic send_bit(input logic b, input bit pop = 1'b0);
        @(posedge clk); #1;
        ps2_data = b;
        strobe   = 1'b1;
        if (pop) pops_left = 1;
        @(posedge clk); #1;
        strobe   = 1'b0;
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pflip = 1'b0, input logic stop = 1'b1,
                              input bit pop = 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~^d ^ pflip);
        send_bit(stop, pop);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (rd_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, rd_valid, 0);
    endtask

    initial begin
        #1;
        chk("rst_valid", rd_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Basic frame with push latency
        exp_q.push_back(8'h1E);
        send_bit(1'b0);
        chk("busy_in_frame", busy, 1);
        for (int i = 0; i < 8; i++) send_bit(i >= 2 && i <= 4);
        send_bit(1'b0);
        chk("valid_before_push", rd_valid, 0);
        send_bit(1'b1);
        chk("push_valid", rd_valid, 1);
        chk("push_count", fifo_count, 1);
        chk("push_data", rd_data, 8'h1E);
        chk("push_busy", busy, 0);
        wait_empty("pop_empties");

        // Break folding
        send_frame(8'hF0);
        chk("f0_no_push", fifo_count, 0);
        exp_q.push_back(8'h9E);
        send_frame(8'h1C);
        chk("break_data", rd_data, 8'h9E);
        exp_q.push_back(8'hE0);
        exp_q.push_back(8'hC8);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        wait_empty("ext_break_drain");

        // Parity and stop errors
        send_frame(8'h1C, 1'b1);
        chk("par_ferr", frame_err, 1);
        chk("par_count", fifo_count, 0);
        @(posedge clk); #1;
        chk("par_ferr_pulse", frame_err, 0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("stop_ferr", frame_err, 1);
        chk("stop_count", fifo_count, 0);

        // An error discards a pending break prefix
        send_frame(8'hF0);
        send_frame(8'h1C, 1'b1);
        exp_q.push_back(8'h1E);
        send_frame(8'h1C);
        wait_empty("break_cleared_drain");

        // Inter-bit timeout
        begin
            int n = 0;
            send_bit(1'b0);
            for (int i = 0; i < 4; i++) send_bit(1'b1);
            while (!frame_err && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("timeout_latency", n, TMO);
            chk("timeout_busy", busy, 0);
        end
        exp_q.push_back(8'h01);
        send_frame(8'h76);
        wait_empty("after_timeout_drain");

        // Overflow with no reads
        drain = 1'b0;
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h05);
        send_frame(8'h16);
        send_frame(8'h1E);
        send_frame(8'h26);
        send_frame(8'h25);
        chk("full_no_ovf", overflow, 0);
        send_frame(8'h2E);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", rd_data, 8'h02);
        drain = 1'b1;
        wait_empty("ovf_drain");
        chk("ovf_sticky", overflow, 1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Full FIFO with a pop coinciding with the push
        drain = 1'b0;
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h09);
        exp_q.push_back(8'h0A);
        send_frame(8'h36);
        send_frame(8'h3D);
        send_frame(8'h3E);
        send_frame(8'h46);
        chk("full_count", fifo_count, 4);
        exp_q.push_back(8'h0B);
        send_frame(8'h45, 1'b0, 1'b1, 1'b1);
        chk("pushpop_count", fifo_count, 4);
        chk("pushpop_ovf", overflow, 0);
        drain = 1'b1;
        wait_empty("pushpop_drain");

        // Asynchronous reset mid-frame
        drain = 1'b0;
        send_frame(8'h1C);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("pre_reset_count", fifo_count, 1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("areset_valid", rd_valid, 0);
        chk("areset_count", fifo_count, 0);
        chk("areset_data", rd_data, 0);
        chk("areset_busy", busy, 0);
        chk("areset_ferr", frame_err, 0);
        #3;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("release_ferr", frame_err, 0);
        drain = 1'b1;
        exp_q.push_back(8'h1C);
        send_frame(8'h5A);
        wait_empty("final_drain");
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
